shift_serializer: RTL

//   Parametrised parallel-to-serial shift register with load handshake and beat counter.

---
 rtl/shift_pkg.sv | 25 ++
 rtl/shift_serializer.sv | 95 +++++++++
 2 files changed

// File: rtl/shift_pkg.sv
// Shared types and elaboration helpers for the parallel-to-serial shifter.
package shift_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_STEP  = 1;

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/shift_serializer.sv
// Parallel-to-serial shift register: load a word, emit STEP bits per shift_en beat,
// back-fill from ser_in, and pulse done once the last beat has left.
module shift_serializer
  import shift_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int STEP      = DEFAULT_STEP,
  parameter bit MSB_FIRST = 1'b1,
  parameter int TAP       = 7,
  localparam int BEATS    = WIDTH / STEP,
  localparam int CW       = clog2(BEATS + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  input  logic [STEP-1:0]  ser_in,
  input  logic             abort,
  output logic [WIDTH-1:0] shift_data,
  output logic [STEP-1:0]  ser_out,
  output logic             msb_out,
  output logic             tap_out,
  output logic             busy,
  output logic [CW-1:0]    beats_left,
  output logic             done
);

  if (WIDTH % STEP != 0) begin : g_bad_step
    $error("shift_serializer: WIDTH must be a multiple of STEP");
  end
  if (TAP < 0 || TAP >= WIDTH) begin : g_bad_tap
    $error("shift_serializer: TAP must index a bit of shift_data");
  end

  state_t           state;
  logic [WIDTH-1:0] shifted;

  // Next register image for one beat; a single-beat word is replaced wholesale.
  if (STEP == WIDTH) begin : g_whole
    assign shifted = ser_in;
  end else if (MSB_FIRST) begin : g_left
    assign shifted = {shift_data[WIDTH-STEP-1:0], ser_in};
  end else begin : g_right
    assign shifted = {ser_in, shift_data[WIDTH-1:STEP]};
  end

  if (MSB_FIRST) begin : g_out_msb
    assign ser_out = shift_data[WIDTH-1 -: STEP];
  end else begin : g_out_lsb
    assign ser_out = shift_data[STEP-1:0];
  end

  assign msb_out    = shift_data[WIDTH-1];
  assign tap_out    = shift_data[TAP];
  assign load_ready = (state == IDLE);
  assign busy       = (state == SHIFT);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      shift_data <= '0;
      beats_left <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // An abort in IDLE swallows a coincident load.
          if (load_valid && !abort) begin
            shift_data <= load_data;
            beats_left <= CW'(BEATS);
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          if (abort) begin
            beats_left <= '0;
            state      <= IDLE;
          end else if (shift_en) begin
            shift_data <= shifted;
            beats_left <= beats_left - CW'(1);
            if (beats_left == CW'(1)) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
